// File: rtl/vector_mem_ctrl.sv
// Main-memory stage: single-port vector array fronted by a small write buffer.
// Loads forward from the newest matching buffered write; init_en preloads the array directly.
module vector_mem_ctrl #(
  parameter int CORES     = 32,
  parameter int BITS      = 16,
  parameter int ADDR_BITS = 8,
  parameter int WB_DEPTH  = 4,
  localparam int W        = CORES * BITS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_ctrl,
  input  logic [15:0]  load_addr,
  input  logic         write_ctrl,
  input  logic [15:0]  write_addr_main,
  input  logic [W-1:0] write_data_main,
  input  logic         init_en,
  input  logic [15:0]  init_addr,
  input  logic [W-1:0] init_data,
  output logic [W-1:0] load_data,
  output logic         load_valid,
  output logic         stall,
  output logic         buf_empty,
  output logic         err_drop
);

  localparam int PW    = $clog2(WB_DEPTH);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [W-1:0]         mem [DEPTH];
  logic [ADDR_BITS-1:0] wb_addr [WB_DEPTH];
  logic [W-1:0]         wb_data [WB_DEPTH];

  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg;

  logic [ADDR_BITS-1:0] load_idx, write_idx, init_idx;
  logic                 push, drain;
  logic [WB_DEPTH-1:0]  entry_match;
  logic                 hit;
  logic [W-1:0]         hit_data;
  logic [PW-1:0]        scan_idx;
  logic                 unused_addr_bits;

  // Addresses wrap modulo the array depth; the upper bits are intentionally ignored.
  assign load_idx  = load_addr[ADDR_BITS-1:0];
  assign write_idx = write_addr_main[ADDR_BITS-1:0];
  assign init_idx  = init_addr[ADDR_BITS-1:0];
  assign unused_addr_bits = ^{load_addr[15:ADDR_BITS], write_addr_main[15:ADDR_BITS],
                              init_addr[15:ADDR_BITS]};

  assign stall     = (count_reg == (PW+1)'(WB_DEPTH));
  assign buf_empty = (count_reg == '0);
  assign push      = write_ctrl && !stall;
  assign drain     = !init_en && !load_ctrl && (count_reg != '0) && !reset;

  // An entry is live when its distance from head is below count.
  for (genvar gi = 0; gi < WB_DEPTH; gi++) begin : g_match
    logic [PW-1:0] age;
    assign age             = PW'(gi) - head_reg;
    assign entry_match[gi] = ({1'b0, age} < count_reg) && (wb_addr[gi] == load_idx);
  end

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      scan_idx = head_reg + PW'(k);
      if (entry_match[scan_idx]) begin
        hit      = 1'b1;
        hit_data = wb_data[scan_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      wb_addr[tail_reg] <= write_idx;
      wb_data[tail_reg] <= write_data_main;
    end
  end

  // Single array write port: init beats drain; loads simply suppress drain.
  always_ff @(posedge clock) begin
    if (init_en) begin
      mem[init_idx] <= init_data;
    end else if (drain) begin
      mem[wb_addr[head_reg]] <= wb_data[head_reg];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      err_drop   <= 1'b0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (drain) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, drain})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (write_ctrl && stall) begin
        err_drop <= 1'b1;
      end
      load_valid <= load_ctrl;
      if (load_ctrl) begin
        load_data <= hit ? hit_data : mem[load_idx];
      end
    end
  end

endmodule
